inv_mix_columns_serial: RTL and testbench
=========================================

Name: inv_mix_columns_serial

Overview:
- Column-serial InvMixColumns stage for the AES decryption datapath.
- Accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per cycle over 4 cycles.
- Presents the 128-bit result over a valid/ready handshake.
- Sits between the InvSubBytes/AddRoundKey stage and the next round register. The GF(2^8) multiply logic is built from the AND/XOR primitive cells.

Parameters:
- NUM_COLS, 4, columns per state (fixed at 4 for AES; counter width derived from it)
- COL_W, 32, bits per column (4 bytes)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  stage can accept a state
- in_state  input  128  state; byte 0 = [127:120]; column c = [127-32c -: 32], row 0 = MSB byte
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_state  output  128  InvMixColumns(in_state), same byte order

Behaviour:
- Reset (clk edge with rst=1):
  - state := IDLE, col_cnt := 0, work register := 0.
  - in_ready = 1 in IDLE, so it reads 1 after reset; out_valid = 0; out_state = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_state into the work register, col_cnt := 0, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle: column col_cnt of the work register := InvMixColumn(that column); col_cnt++.
  - When col_cnt == 3 is processed: go to DONE, col_cnt := 0.
- DONE:
  - out_valid = 1; out_state = work register, held stable while out_ready = 0.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready = 0 in DONE, so there is no same-cycle re-accept.
- Latency and throughput:
  - Accept at edge k → out_valid high after edge k+4.
  - Minimum 6 cycles per state (accept, 4 BUSY, DONE handshake).
- InvMixColumn of column (a0..a3), row i:
  - b_i = 0e·a_i ^ 0b·a_(i+1) ^ 0d·a_(i+2) ^ 09·a_(i+3), indices mod 4.
  - GF(2^8) with polynomial 0x11B.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0).
- Boundary conditions:
  - in_valid while BUSY/DONE is ignored; upstream must hold it.
  - out_ready while not DONE has no effect.
  - rst mid-BUSY/DONE discards the state and returns to IDLE; out_valid is 0 after that edge.
  - col_cnt must not exceed 3; any illegal state encoding recovers to IDLE.

Optional Feature:
- Macro: INV_MIX_COLUMNS_ARK_EN
- Defined:
  - Adds port in_round_key (input, 128), latched together with in_state on accept.
  - Work register loads in_state ^ in_round_key (fused AddRoundKey, then InvMixColumns).
  - Latency unchanged.
- Undefined:
  - Port absent; work register loads in_state directly.

Decomposition:
- Package aes_pkg:
  - typedef state_t = logic [127:0]; typedef col_t = logic [31:0]; typedef byte_t = logic [7:0].
  - enum imc_state_e {IDLE, BUSY, DONE}.
  - Constant AES_POLY = 8'h1B.
  - Functions xtime() and gf_mul_const() (×09, ×0b, ×0d, ×0e).
- Sub-module inv_mix_column_word: purely combinational, col_t in → col_t out; one instance muxed by col_cnt.
- The top holds the FSM, counter, work register and handshake.

Test Plan:
1. Reset check: assert rst 2 cycles → in_ready=1, out_valid=0, out_state=0; rst during BUSY → next cycle IDLE, out_valid stays 0.
2. FIPS-197 vector: in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6 accepted at edge k → out_valid after edge k+4, out_state=db135345_f20a225c_01010101_d4d4d4d5.
3. Identity: in_state = all columns c6c6c6c6 → out_state identical; all-zero → all-zero.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_state stable and in_ready=0; raise out_ready → IDLE next cycle, in_ready=1.
5. Back-to-back: in_valid held high with 3 distinct vectors and out_ready=1 → each accepted exactly once, results in order, 6-cycle spacing, no in_ready during BUSY/DONE.
6. With INV_MIX_COLUMNS_ARK_EN: in_round_key = in_state (vector 2) → out_state = 0. With in_round_key=0 → result matches test 2.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, state encoding and GF(2^8) constant-multiply helpers
// for the column-serial InvMixColumns stage.
package aes_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned STATE_W  = NUM_COLS * COL_W;
  localparam int unsigned CNT_W    = $clog2(NUM_COLS);

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  localparam byte_t AES_POLY = 8'h1B;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Constant multiply for the four InvMixColumns coefficients only.
  function automatic byte_t gf_mul_const(input byte_t x, input byte_t c);
    byte_t x2;
    byte_t x4;
    byte_t x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h09:   return x8 ^ x;
      8'h0b:   return x8 ^ x2 ^ x;
      8'h0d:   return x8 ^ x4 ^ x;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumn of one 32-bit column; row 0 is the MSB byte.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  col_t col_i,
  output col_t col_c_o
);

  byte_t a [NUM_COLS];
  byte_t b [NUM_COLS];

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_row
    localparam int unsigned HI  = COL_W - 1 - BYTE_W * g;
    localparam int unsigned I1  = (g + 1) % NUM_COLS;
    localparam int unsigned I2  = (g + 2) % NUM_COLS;
    localparam int unsigned I3  = (g + 3) % NUM_COLS;

    assign a[g] = col_i[HI -: BYTE_W];
    assign b[g] = gf_mul_const(a[g],  8'h0e) ^ gf_mul_const(a[I1], 8'h0b)
                ^ gf_mul_const(a[I2], 8'h0d) ^ gf_mul_const(a[I3], 8'h09);
    assign col_c_o[HI -: BYTE_W] = b[g];
  end

endmodule

// File: rtl/inv_mix_columns_serial.sv
// Column-serial InvMixColumns stage: one column per cycle, valid/ready on both sides.
// Define INV_MIX_COLUMNS_ARK_EN to fuse an AddRoundKey (in_round_key) into the load.
module inv_mix_columns_serial
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
`ifdef INV_MIX_COLUMNS_ARK_EN
  input  logic [STATE_W-1:0] in_round_key,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  imc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           work_q, work_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  state_t           load_val;
  col_t             col_sel;
  col_t             col_mixed;

`ifdef INV_MIX_COLUMNS_ARK_EN
  assign load_val = in_state ^ in_round_key;
`else
  assign load_val = in_state;
`endif

  // Select the column currently being transformed.
  always_comb begin
    col_sel = work_q[STATE_W-1 -: COL_W];
    case (cnt_q)
      2'd0:    col_sel = work_q[127:96];
      2'd1:    col_sel = work_q[95:64];
      2'd2:    col_sel = work_q[63:32];
      2'd3:    col_sel = work_q[31:0];
      default: col_sel = work_q[127:96];
    endcase
  end

  inv_mix_column_word u_word (
    .col_i   (col_sel),
    .col_c_o (col_mixed)
  );

  // State register plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state, column counter and work register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          work_d  = load_val;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        case (cnt_q)
          2'd0:    work_d[127:96] = col_mixed;
          2'd1:    work_d[95:64]  = col_mixed;
          2'd2:    work_d[63:32]  = col_mixed;
          2'd3:    work_d[31:0]   = col_mixed;
          default: work_d         = work_q;
        endcase
        if (cnt_q == CNT_W'(NUM_COLS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the handshake lines are flops.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// Directed self-checking bench for inv_mix_columns_serial (FIPS-197 vectors,
// identity columns, backpressure, back-to-back, reset; ARK when the macro is set).
module tb_inv_mix_columns_serial;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
`ifdef INV_MIX_COLUMNS_ARK_EN
  logic [127:0] in_round_key;
`endif

  int checks;
  int errors;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] C6_ALL   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] MIX_IN   = 128'h4d7ebdf8_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] MIX_OUT  = 128'h2d26314c_01010101_c6c6c6c6_d4d4d4d5;

  inv_mix_columns_serial dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
`ifdef INV_MIX_COLUMNS_ARK_EN
    .in_round_key (in_round_key),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state    (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one state from IDLE; returns result and edges from accept to out_valid (-1 on timeout).
  task automatic xact(input logic [127:0] s, output logic [127:0] r, output int lat);
    in_valid = 1'b1;
    in_state = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_state !== 128'h0) begin
      errors++; $display("FAIL reset_out_state got %h want 0", out_state);
    end
    // Reset while BUSY
    in_valid = 1'b1;
    in_state = FIPS_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_busy got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_state !== 128'h0) begin
      errors++; $display("FAIL reset_busy_state got %h want 0", out_state);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_busy_quiet got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_fips();
    logic [127:0] r;
    int lat;
    xact(FIPS_IN, r, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL fips_latency got %0d want 4", lat);
    end
    checks++;
    if (r !== FIPS_OUT) begin
      errors++; $display("FAIL fips_data got %h want %h", r, FIPS_OUT);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL fips_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_identity();
    logic [127:0] r;
    int lat;
    xact(C6_ALL, r, lat);
    checks++;
    if (lat !== 4 || r !== C6_ALL) begin
      errors++; $display("FAIL ident_c6 got %h lat %0d want %h lat 4", r, lat, C6_ALL);
    end
    xact(128'h0, r, lat);
    checks++;
    if (lat !== 4 || r !== 128'h0) begin
      errors++; $display("FAIL ident_zero got %h lat %0d want 0 lat 4", r, lat);
    end
    xact(MIX_IN, r, lat);
    checks++;
    if (r !== MIX_OUT) begin
      errors++; $display("FAIL mixed_cols got %h want %h", r, MIX_OUT);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    in_valid = 1'b1;
    in_state = FIPS_IN;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_timeout got out_valid=0 want 1");
    end
    // in_valid stays high throughout DONE and must be ignored
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== FIPS_OUT) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b rdy=%b %h want 1/0 %h",
                 i, out_valid, in_ready, out_state, FIPS_OUT);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [3];
    logic [127:0] exp [3];
    int acc_cyc [3];
    int out_cyc [3];
    int idx;
    int got;
    int cyc;
    bit accept;
    vec[0] = FIPS_IN; vec[1] = C6_ALL;   vec[2] = MIX_IN;
    exp[0] = FIPS_OUT; exp[1] = C6_ALL;  exp[2] = MIX_OUT;
    idx = 0; got = 0; cyc = 0;
    in_valid  = 1'b1;
    in_state  = vec[0];
    out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      accept = in_ready && (idx < 3);
      @(posedge clk); #1;
      cyc++;
      if (accept) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) in_state = vec[idx];
        else in_valid = 1'b0;
      end
      if (in_ready && out_valid) begin
        checks++; errors++;
        $display("FAIL b2b_overlap cycle %0d got in_ready=1 with out_valid=1 want exclusive", cyc);
      end
      if (out_valid) begin
        checks++;
        if (out_state !== exp[got]) begin
          errors++; $display("FAIL b2b_data %0d got %h want %h", got, out_state, exp[got]);
        end
        out_cyc[got] = cyc;
        got++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (got !== 3 || idx !== 3) begin
      errors++; $display("FAIL b2b_count got %0d results %0d accepts want 3/3", got, idx);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_cyc[i] - acc_cyc[i] !== 4) begin
          errors++; $display("FAIL b2b_latency %0d got %0d want 4", i, out_cyc[i] - acc_cyc[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
          errors++; $display("FAIL b2b_spacing %0d got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef INV_MIX_COLUMNS_ARK_EN
  task automatic test_ark();
    logic [127:0] r;
    int lat;
    in_round_key = FIPS_IN;
    xact(FIPS_IN, r, lat);
    checks++;
    if (lat !== 4 || r !== 128'h0) begin
      errors++; $display("FAIL ark_cancel got %h lat %0d want 0 lat 4", r, lat);
    end
    in_round_key = 128'h0;
    xact(FIPS_IN, r, lat);
    checks++;
    if (r !== FIPS_OUT) begin
      errors++; $display("FAIL ark_zero_key got %h want %h", r, FIPS_OUT);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_ARK_EN
    in_round_key = '0;
`endif
    test_reset();
    test_fips();
    test_identity();
    test_backpressure();
    test_back_to_back();
`ifdef INV_MIX_COLUMNS_ARK_EN
    test_ark();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
